muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative multiply/divide unit in the EX stage, beside the ALU, fed by the same src1/src2 operand buses.
//   Runs MIPS mult/multu/div/divu over bit_size cycles and writes the 2*bit_size result to internal HI/LO registers.
//   Downstream mfhi/mflo paths read HI/LO directly. The pipeline stalls on busy.
// PARAMETERS
//   bit_size   32   operand width; HI and LO are each bit_size wide
// PORTS
//   clk          in   1         single clock; all state updates on rising edge
//   rst          in   1         reset, asynchronous, active-low (0 = reset)
//   start        in   1         request a new operation; sampled only in IDLE
//   op           in   2         00 multu, 01 mult (signed), 10 divu, 11 div (signed)
//   src1         in   bit_size  multiplicand / dividend
//   src2         in   bit_size  multiplier / divisor
//   hi           out  bit_size  HI register: product upper half / remainder
//   lo           out  bit_size  LO register: product lower half / quotient
//   busy         out  1         1 while state != IDLE
//   done         out  1         registered one-cycle pulse; HI/LO hold the new result this cycle
//   div_by_zero  out  1         registered; 1 with done when a div/divu had src2 == 0
// BEHAVIOUR
//   Reset (rst = 0, any time, including mid-operation):
//     - state = IDLE; hi, lo, done, div_by_zero = 0; iteration counter = 0; operation in progress is discarded.
//   FSM:
//     - IDLE -> CALC on start = 1. The same edge latches op, |src1| and |src2|
//       (absolute value only for signed ops), result signs, and counter = 0.
//     - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per edge; counter++.
//     - CALC -> FIN on the edge that completes step bit_size (counter == bit_size-1).
//     - FIN -> IDLE on the next edge. That edge applies sign correction, writes hi/lo, and sets done = 1.
//   Latency: start accepted at edge E0; busy = 1 from E0 until E(bit_size+1).
//     At E(bit_size+1) (E33 at default), hi/lo are updated and done = 1 for exactly one cycle.
//   Handshake:
//     - start while busy is ignored; operands and op are not re-sampled.
//     - start in the cycle done = 1 is accepted (state is IDLE), giving back-to-back operations.
//     - done and div_by_zero clear on the following edge unless a new result completes.
//   Arithmetic:
//     - multu: {hi,lo} = unsigned src1*src2.
//     - mult: {hi,lo} = signed 2*bit_size-bit product.
//     - divu: lo = src1/src2, hi = src1%src2 (unsigned).
//     - div: quotient truncated toward zero; remainder takes the dividend's sign.
//     - div of 0x80000000 by 0xFFFFFFFF gives lo = 0x80000000, hi = 0 (no trap).
//   Divide by zero (div or divu with src2 == 0):
//     - full latency kept; lo = src1, hi = 0, div_by_zero = 1 with done.
//   hi/lo hold their value between operations and during CALC; only the FIN edge writes them.
//   op is ignored while not starting; the behaviour of every op value (00, 01, 10, 11) is defined above.
// TESTING
//   1. multu src1=0xFFFFFFFF, src2=0xFFFFFFFF
//      -> done 33 edges after start; hi=0xFFFFFFFE, lo=0x00000001; busy low with done.
//   2. mult src1=-3 (0xFFFFFFFD), src2=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//   3. div src1=-7, src2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//      divu src1=100, src2=7 -> lo=14, hi=2.
//   4. divu src1=100, src2=0 -> done at same latency; lo=100, hi=0, div_by_zero=1 for one cycle.
//   5. Interference, back-to-back:
//      - Pulse start with new operands at edge 10 of a busy operation -> ignored; original result produced.
//      - Start in the done cycle -> second result 33 edges later.
//   6. Reset mid-op: rst=0 at edge 15 of a mult -> immediately busy=0, hi=lo=0, no done.
//      After release, a fresh multu 6*7 -> lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_if.sv
// Operand/result bundle between the EX-stage issue logic and the iterative
// multiply/divide unit.
interface muldiv_if #(
    parameter int bit_size = 32
) ();
    logic                start;
    logic [1:0]          op;
    logic [bit_size-1:0] src1;
    logic [bit_size-1:0] src2;
    logic [bit_size-1:0] hi;
    logic [bit_size-1:0] lo;
    logic                busy;
    logic                done;
    logic                div_by_zero;

    modport master (
        output start, op, src1, src2,
        input  hi, lo, busy, done, div_by_zero
    );

    modport slave (
        input  start, op, src1, src2,
        output hi, lo, busy, done, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS mult/multu/div/divu: one shift-add or restoring shift-subtract
// step per cycle on magnitudes, sign fix-up and HI/LO write in the FIN cycle.
module muldiv_unit #(
    parameter int bit_size = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CW = (bit_size > 1) ? $clog2(bit_size) : 1;
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_FIN  = 2'b10;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            op_q, op_d;
    logic [bit_size-1:0]   a_q, a_d;
    logic [bit_size-1:0]   dvd_q, dvd_d;
    logic [2*bit_size:0]   acc_q, acc_d;
    logic                  neg_res_q, neg_res_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  dbz_q, dbz_d;
    logic [bit_size-1:0]   hi_q, hi_d;
    logic [bit_size-1:0]   lo_q, lo_d;
    logic                  done_q, done_d;
    logic                  dbz_out_q, dbz_out_d;

    logic                  s1_neg_s, s2_neg_s;
    logic [bit_size-1:0]   abs1_s, abs2_s;
    logic [bit_size:0]     sum_s, trial_s;
    logic [2*bit_size:0]   shifted_s;
    logic [2*bit_size-1:0] prod_s;
    logic [bit_size-1:0]   quo_s, rem_s;

    assign s1_neg_s = bus.op[0] & bus.src1[bit_size-1];
    assign s2_neg_s = bus.op[0] & bus.src2[bit_size-1];
    assign abs1_s   = s1_neg_s ? -bus.src1 : bus.src1;
    assign abs2_s   = s2_neg_s ? -bus.src2 : bus.src2;

    // Multiply keeps the multiplier in acc[W-1:0] and accumulates above it;
    // divide keeps remainder:quotient in acc and shifts left each step.
    assign sum_s     = acc_q[0] ? (acc_q[2*bit_size:bit_size] + {1'b0, a_q})
                                : acc_q[2*bit_size:bit_size];
    assign shifted_s = {acc_q[2*bit_size-1:0], 1'b0};
    assign trial_s   = shifted_s[2*bit_size:bit_size] - {1'b0, a_q};

    assign prod_s = neg_res_q ? -acc_q[2*bit_size-1:0] : acc_q[2*bit_size-1:0];
    assign quo_s  = neg_res_q ? -acc_q[bit_size-1:0] : acc_q[bit_size-1:0];
    assign rem_s  = neg_rem_q ? -acc_q[2*bit_size-1:bit_size] : acc_q[2*bit_size-1:bit_size];

    // Next-state logic for the IDLE/CALC/FIN sequencer and datapath
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        dvd_d     = dvd_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_out_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_CALC;
                    cnt_d     = {CW{1'b0}};
                    op_d      = bus.op;
                    dvd_d     = bus.src1;
                    a_d       = bus.op[1] ? abs2_s : abs1_s;
                    acc_d     = {{(bit_size+1){1'b0}}, (bus.op[1] ? abs1_s : abs2_s)};
                    neg_res_d = s1_neg_s ^ s2_neg_s;
                    neg_rem_d = s1_neg_s;
                    dbz_d     = bus.op[1] & (bus.src2 == {bit_size{1'b0}});
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (op_q[1]) begin
                    if (!trial_s[bit_size]) begin
                        acc_d = {trial_s, shifted_s[bit_size-1:1], 1'b1};
                    end else begin
                        acc_d = shifted_s;
                    end
                end else begin
                    acc_d = {1'b0, sum_s, acc_q[bit_size-1:1]};
                end
                if (cnt_q == CW'(bit_size - 1)) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_FIN: begin
                state_d   = ST_IDLE;
                done_d    = 1'b1;
                dbz_out_d = dbz_q;
                if (dbz_q) begin
                    hi_d = {bit_size{1'b0}};
                    lo_d = dvd_q;
                end else if (op_q[1]) begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end else begin
                    hi_d = prod_s[2*bit_size-1:bit_size];
                    lo_d = prod_s[bit_size-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any operation in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CW{1'b0}};
            op_q      <= 2'b00;
            a_q       <= {bit_size{1'b0}};
            dvd_q     <= {bit_size{1'b0}};
            acc_q     <= {(2*bit_size+1){1'b0}};
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= {bit_size{1'b0}};
            lo_q      <= {bit_size{1'b0}};
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            dvd_q     <= dvd_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit against a plain-arithmetic HI/LO model,
// plus directed latency, interference, back-to-back and reset cases.
module tb_muldiv_unit;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    muldiv_if #(.bit_size(32)) bus ();

    muldiv_unit #(.bit_size(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l, output logic z);
        logic [63:0] p;
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        z  = 1'b0;
        h  = 32'd0;
        l  = 32'd0;
        if (o == 2'b00) begin
            p = {32'd0, a} * {32'd0, b};
            h = p[63:32];
            l = p[31:0];
        end else if (o == 2'b01) begin
            p = 64'(sa * sb);
            h = p[63:32];
            l = p[31:0];
        end else if (b == 32'd0) begin
            z = 1'b1;
            l = a;
            h = 32'd0;
        end else if (o == 2'b10) begin
            l = a / b;
            h = a % b;
        end else begin
            p = 64'(sa / sb);
            l = p[31:0];
            p = 64'(sa % sb);
            h = p[31:0];
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            5:       return 32'(-$urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit chain, input bit intf);
        logic [31:0] eh;
        logic [31:0] el;
        logic        ez;
        int          n;
        ref_op(o, a, b, eh, el, ez);
        if (!chain) begin
            @(posedge clk); #1;
            chk({nm, "_done_clr"}, 64'(bus.done), 64'd0);
            chk({nm, "_dbz_clr"}, 64'(bus.div_by_zero), 64'd0);
            chk({nm, "_idle"}, 64'(bus.busy), 64'd0);
            chk({nm, "_hold_hi"}, 64'(bus.hi), 64'(prev_hi));
            chk({nm, "_hold_lo"}, 64'(bus.lo), 64'(prev_lo));
            @(negedge clk);
        end
        bus.start = 1'b1;
        bus.op    = o;
        bus.src1  = a;
        bus.src2  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.src1  = 32'($urandom);
        bus.src2  = 32'($urandom);
        chk({nm, "_busy"}, 64'(bus.busy), 64'd1);
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            if (intf && n == 9) begin
                bus.start = 1'b1;
                bus.op    = ~o;
                bus.src1  = ~a;
                bus.src2  = b + 32'd1;
            end
            @(posedge clk); #1;
            n++;
            if (n == 10) bus.start = 1'b0;
            if (n == 20) chk({nm, "_hold_mid"}, 64'(bus.hi), 64'(prev_hi));
        end
        chk({nm, "_latency"}, 64'(n), 64'd33);
        chk({nm, "_hi"}, 64'(bus.hi), 64'(eh));
        chk({nm, "_lo"}, 64'(bus.lo), 64'(el));
        chk({nm, "_dbz"}, 64'(bus.div_by_zero), 64'(ez));
        chk({nm, "_busy_low"}, 64'(bus.busy), 64'd0);
        prev_hi = eh;
        prev_lo = el;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total     = 0;
        bad       = 0;
        prev_hi   = 32'd0;
        prev_lo   = 32'd0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.src1  = 32'd0;
        bus.src2  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        do_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        do_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        do_op("divu", 2'b10, 32'd100, 32'd7, 1'b0, 1'b0);
        do_op("divu_zero", 2'b10, 32'd100, 32'd0, 1'b0, 1'b0);
        do_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op("div_zero_s", 2'b11, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);
        do_op("interfere", 2'b01, 32'h1234_5678, 32'hFEDC_BA98, 1'b0, 1'b1);
        do_op("b2b", 2'b10, 32'hDEAD_BEEF, 32'd13, 1'b1, 1'b0);

        // reset asserted partway through a signed multiply
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.src1  = 32'h7654_3210;
        bus.src2  = 32'h0000_0777;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_hi", 64'(bus.hi), 64'd0);
        chk("mid_rst_lo", 64'(bus.lo), 64'd0);
        chk("mid_rst_done", 64'(bus.done), 64'd0);
        repeat (20) @(posedge clk);
        #1 chk("mid_rst_no_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst     = 1'b1;
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        do_op("post_rst", 2'b00, 32'd6, 32'd7, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            do_op("rnd", 2'($urandom_range(0, 3)), pick(), pick(),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 5) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
